// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the ALU with mul/div.
package alu_pkg;

    localparam int unsigned SEL_W = 4;

    typedef logic [SEL_W-1:0] alu_sel_t;

    localparam alu_sel_t SEL_AND   = 4'b0000;
    localparam alu_sel_t SEL_OR    = 4'b0001;
    localparam alu_sel_t SEL_ADD   = 4'b0010;
    localparam alu_sel_t SEL_SLTU  = 4'b0011;
    localparam alu_sel_t SEL_XOR   = 4'b0100;
    localparam alu_sel_t SEL_SUB   = 4'b0110;
    localparam alu_sel_t SEL_SLT   = 4'b0111;
    localparam alu_sel_t SEL_MUL   = 4'b1000;
    localparam alu_sel_t SEL_MULH  = 4'b1001;
    localparam alu_sel_t SEL_MULHU = 4'b1010;
    localparam alu_sel_t SEL_DIV   = 4'b1011;
    localparam alu_sel_t SEL_NOR   = 4'b1100;
    localparam alu_sel_t SEL_DIVU  = 4'b1101;
    localparam alu_sel_t SEL_REM   = 4'b1110;
    localparam alu_sel_t SEL_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multi-cycle ops: every code with the top bit set except NOR.
    function automatic logic is_muldiv(input alu_sel_t sel);
        return sel[3] && (sel != SEL_NOR);
    endfunction

    // Division/remainder ops share the restoring datapath.
    function automatic logic is_div(input alu_sel_t sel);
        return (sel == SEL_DIV) || (sel == SEL_DIVU) || (sel == SEL_REM) || (sel == SEL_REMU);
    endfunction

    // Ops whose operands are treated as two's complement (MUL low half is sign-agnostic).
    function automatic logic is_signed(input alu_sel_t sel);
        return (sel == SEL_MULH) || (sel == SEL_DIV) || (sel == SEL_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide core: one product/quotient bit per cycle on operand magnitudes.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [SEL_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    p_q;
    logic [XLEN-1:0]  m_q;
    alu_sel_t         op_q;
    logic             neg_hi_q;
    logic             neg_r_q;
    logic             div0_q;
    logic [XLEN-1:0]  a_q;

    logic             neg_a;
    logic             neg_b;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;

    logic [XLEN:0]    mul_sum;
    logic [PW-1:0]    mul_nxt;
    logic [XLEN:0]    div_sh;
    logic [XLEN:0]    div_diff;
    logic [PW-1:0]    div_nxt;
    logic [PW-1:0]    p_nxt;
    logic [PW-1:0]    prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;

    // Operand magnitudes and signs captured at start.
    always_comb begin
        neg_a = is_signed(op) && a[XLEN-1];
        neg_b = is_signed(op) && b[XLEN-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide ({rem, quo} in p).
    always_comb begin
        mul_sum  = {1'b0, p_q[PW-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_nxt  = {mul_sum, p_q[XLEN-1:1]};
        div_sh   = {p_q[PW-1:XLEN], p_q[XLEN-1]};
        div_diff = div_sh - {1'b0, m_q};
        if (!div_diff[XLEN]) begin
            div_nxt = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        end else begin
            div_nxt = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end
        p_nxt = is_div(op_q) ? div_nxt : mul_nxt;
    end

    // Final result from the post-iteration value, with sign and divide-by-zero fix-up.
    always_comb begin
        prod     = neg_hi_q ? -p_nxt : p_nxt;
        quo      = p_nxt[XLEN-1:0];
        rem      = p_nxt[PW-1:XLEN];
        result_c = '0;
        case (op_q)
            SEL_MUL:             result_c = prod[XLEN-1:0];
            SEL_MULH, SEL_MULHU: result_c = prod[PW-1:XLEN];
            SEL_DIV, SEL_DIVU:   result_c = div0_q ? '1  : (neg_hi_q ? -quo : quo);
            SEL_REM, SEL_REMU:   result_c = div0_q ? a_q : (neg_r_q  ? -rem : rem);
            default:             result_c = '0;
        endcase
        done_c = run_q && (cnt_q == CNT_W'(XLEN - 1));
    end

    // Iteration state: load on start, step while running, stop on abort or last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            op_q     <= '0;
            neg_hi_q <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
        end else if (abort) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            p_q      <= {XLEN'(0), mag_a};
            m_q      <= mag_b;
            op_q     <= op;
            neg_hi_q <= neg_a ^ neg_b;
            neg_r_q  <= neg_a;
            div0_q   <= (b == '0);
            a_q      <= a;
        end else if (run_q) begin
            p_q   <= p_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered XLEN-bit ALU with valid/ready handshake and iterative RV32M multiply/divide.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] aluSel,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_out,
    output logic             busy
);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] alu_out_d;
    logic [XLEN-1:0] simple_res;
    logic            start_c;
    logic            md_done_c;
    logic [XLEN-1:0] md_result_c;

    // Single-cycle datapath; unused codes and disabled M ops yield zero.
    always_comb begin
        simple_res = '0;
        case (aluSel)
            SEL_AND:  simple_res = rs1_data & rs2_data;
            SEL_OR:   simple_res = rs1_data | rs2_data;
            SEL_ADD:  simple_res = rs1_data + rs2_data;
            SEL_SLTU: simple_res = XLEN'(rs1_data < rs2_data);
            SEL_XOR:  simple_res = rs1_data ^ rs2_data;
            SEL_SUB:  simple_res = rs1_data - rs2_data;
            SEL_SLT:  simple_res = XLEN'($signed(rs1_data) < $signed(rs2_data));
            SEL_NOR:  simple_res = ~(rs1_data | rs2_data);
            default:  simple_res = '0;
        endcase
    end

    // Handshake FSM next state and result capture; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out;
        start_c   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (MULDIV_EN && is_muldiv(aluSel)) begin
                            state_d = BUSY;
                            start_c = 1'b1;
                        end else begin
                            state_d   = DONE;
                            alu_out_d = simple_res;
                        end
                    end
                end
                BUSY: begin
                    if (md_done_c) begin
                        state_d   = DONE;
                        alu_out_d = md_result_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            alu_out   <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d == BUSY);
            alu_out   <= alu_out_d;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (flush),
        .start    (start_c),
        .op       (aluSel),
        .a        (rs1_data),
        .b        (rs2_data),
        .done_c   (md_done_c),
        .result_c (md_result_c)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: vector table plus hold, flush and mid-op reset sequences.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluSel;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [40];
    int   nv = 0;

    alu_muldiv #(
        .XLEN      (32),
        .MULDIV_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluSel    (aluSel),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        vecs[nv] = '{sel, a, b, exp, lat};
        nv++;
    endtask

    // Issue one op from IDLE, scramble inputs after accept, wait for result and consume it.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        in_valid = 1'b1;
        aluSel   = sel;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluSel   = 4'b0010;
        rs1_data = $urandom;
        rs2_data = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = alu_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        int          n;
        logic        seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluSel = '0; rs1_data = '0; rs2_data = '0;

        // Simple ops (latency 1)
        add_vec(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        add_vec(4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
        add_vec(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        add_vec(4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        add_vec(4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1);
        add_vec(4'b0011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1);
        add_vec(4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1);
        add_vec(4'b0000, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1);
        add_vec(4'b0001, 32'h00001200, 32'h00000034, 32'h00001234, 1);
        add_vec(4'b0100, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1);
        add_vec(4'b0101, 32'h00000012, 32'h00000034, 32'h00000000, 1);
        // Multiply (latency 33)
        add_vec(4'b1001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        add_vec(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add_vec(4'b1000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 33);
        add_vec(4'b1000, 32'h00003039, 32'h000003E8, 32'h00BC5EA8, 33);
        add_vec(4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33);
        add_vec(4'b1010, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 33);
        // Divide / remainder
        add_vec(4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        add_vec(4'b1110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        add_vec(4'b1101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 33);
        add_vec(4'b1111, 32'h00000005, 32'h00000000, 32'h00000005, 33);
        add_vec(4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        add_vec(4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        add_vec(4'b1011, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        add_vec(4'b1110, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 33);
        add_vec(4'b1101, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33);
        add_vec(4'b1111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33);
        add_vec(4'b1011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 33);
        add_vec(4'b1110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 33);
        add_vec(4'b1111, 32'h00000007, 32'hFFFFFFF9, 32'h00000007, 33);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_alu_out",   alu_out,        32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < nv; i++) begin
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Result held while consumer stalls; in_valid ignored meanwhile
        in_valid = 1'b1; aluSel = 4'b1011; rs1_data = 32'hFFFFFFF9; rs2_data = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_busy_ready", 32'(in_ready), 32'd0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", 32'(n), 32'd33);
        in_valid = 1'b1; aluSel = 4'b0010; rs1_data = 32'h1; rs2_data = 32'h1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_out", k), alu_out, 32'hFFFFFFFD);
            chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        chk("hold_release_ready", 32'(in_ready), 32'd1);

        // Flush beats a same-cycle accept
        flush = 1'b1; in_valid = 1'b1; aluSel = 4'b0010; rs1_data = 32'h1; rs2_data = 32'h2;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flushacc_ready", 32'(in_ready), 32'd1);
        chk("flushacc_valid", 32'(out_valid), 32'd0);
        chk("flushacc_busy",  32'(busy),      32'd0);

        // Flush at BUSY cycle 10
        in_valid = 1'b1; aluSel = 4'b1011; rs1_data = 32'h64; rs2_data = 32'h7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_busy",  32'(busy),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);

        // Async reset at cycle 12 of a second DIV
        in_valid = 1'b1; aluSel = 4'b1011; rs1_data = 32'hFFFFFFF9; rs2_data = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready),  32'd1);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out",   alu_out,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run_op(4'b0010, 32'd3, 32'd4, res, lat);
        chk("post_add_result",  res,        32'd7);
        chk("post_add_latency", 32'(lat),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
